// File: rtl/seq_count_pkg.sv
// Shared definitions for the BCD up/down counter family.
package seq_count_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic       DIR_UP  = 1'b0;
    localparam logic       DIR_DN  = 1'b1;

    typedef logic [3:0] bcd_digit_t;

    // Replace an out-of-range decade value with zero
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction

    // One decade step up, 9 wraps to 0
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d >= BCD_MAX) ? BCD_MIN : bcd_digit_t'(d + 4'd1);
    endfunction

    // One decade step down, 0 wraps to 9
    function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
        return (d == BCD_MIN) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
    endfunction

endpackage

// File: rtl/seq_count_bcd_nd_digit.sv
// One BCD decade: holds its digit and forwards the carry/borrow to the next decade.
module bcd_digit_cell
    import seq_count_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_d,
    input  logic       step_in,
    input  logic       dir,
    output bcd_digit_t q,
    output logic       step_out
);

    logic w_at_limit;

    // The digit is at its wrap point for the current direction
    assign w_at_limit = (dir == DIR_DN) ? (q == BCD_MIN) : (q == BCD_MAX);
    assign step_out   = step_in & w_at_limit;

    // Priority reset > load > step > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_sanitize(load_d);
        end else if (step_in) begin
            q <= (dir == DIR_DN) ? bcd_dec(q) : bcd_inc(q);
        end
    end

endmodule

// File: rtl/seq_count_bcd_nd.sv
// Multi-decade BCD up/down counter with enable, parallel load and terminal count.
module seq_count_bcd_nd
    import seq_count_pkg::*;
#(
    parameter int unsigned NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   dir,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   out,
    output logic                   tc
);

    logic [NDIGITS:0] w_step;

    // Load blocks counting so the least significant decade only steps when enabled alone
    assign w_step[0] = en & ~load;

    // Ripple the step enable through the decades
    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        bcd_digit_cell u_digit (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .load_d   (load_val[4*k +: 4]),
            .step_in  (w_step[k]),
            .dir      (dir),
            .q        (out[4*k +: 4]),
            .step_out (w_step[k+1])
        );
    end

    // Carry out of the top decade means the next edge wraps the whole count
    assign tc = w_step[NDIGITS] & ~reset;

endmodule

// File: tb/tb_seq_count_bcd_nd.sv
// Bench for seq_count_bcd_nd: directed checks on 2 decades, random checks on 1, 2 and 4 decades.
module tb_seq_count_bcd_nd;

    bit          clk = 1'b0;
    logic        r_reset = 1'b1;
    logic        r_en    = 1'b0;
    logic        r_dir   = 1'b0;
    logic        r_load  = 1'b0;
    logic [31:0] r_lv    = '0;

    logic [3:0]  w_out1;
    logic [7:0]  w_out2;
    logic [15:0] w_out4;
    logic        w_tc1, w_tc2, w_tc4;

    int checks   = 0;
    int failures = 0;

    int m1 = 0, m2 = 0, m4 = 0;

    always #5 clk = ~clk;

    seq_count_bcd_nd #(.NDIGITS(1)) u_dut1 (
        .clk(clk), .reset(r_reset), .en(r_en), .dir(r_dir), .load(r_load),
        .load_val(r_lv[3:0]), .out(w_out1), .tc(w_tc1));
    seq_count_bcd_nd #(.NDIGITS(2)) u_dut2 (
        .clk(clk), .reset(r_reset), .en(r_en), .dir(r_dir), .load(r_load),
        .load_val(r_lv[7:0]), .out(w_out2), .tc(w_tc2));
    seq_count_bcd_nd #(.NDIGITS(4)) u_dut4 (
        .clk(clk), .reset(r_reset), .en(r_en), .dir(r_dir), .load(r_load),
        .load_val(r_lv[15:0]), .out(w_out4), .tc(w_tc4));

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal value of a BCD word, illegal digits read as zero
    function automatic int bcd_to_int(input logic [31:0] v, input int n);
        int acc = 0;
        for (int i = n - 1; i >= 0; i--) begin
            int d;
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 0;
            acc = acc * 10 + d;
        end
        return acc;
    endfunction

    function automatic logic [31:0] int_to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int model_next(input int v, input int n);
        int m = pow10(n);
        if (r_reset) return 0;
        if (r_load) return bcd_to_int(r_lv, n);
        if (!r_en) return v;
        return r_dir ? (v + m - 1) % m : (v + 1) % m;
    endfunction

    function automatic logic model_tc(input int v, input int n);
        int m = pow10(n);
        return r_en && !r_load && !r_reset &&
               ((!r_dir && v == m - 1) || (r_dir && v == 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed cycle on the 2-decade instance with hand-computed expectations
    task automatic dstep(input string tag, input logic r, input logic e, input logic d,
                         input logic l, input logic [7:0] lv,
                         input logic [7:0] exp_out, input logic exp_tc);
        r_reset = r; r_en = e; r_dir = d; r_load = l; r_lv = {24'h0, lv};
        #1;
        check({tag, "_tc"}, {31'b0, w_tc2}, {31'b0, exp_tc});
        @(posedge clk); #1;
        check({tag, "_out"}, {24'b0, w_out2}, {24'b0, exp_out});
    endtask

    // Random cycle checked on all instances against the decimal models
    task automatic rstep();
        r_reset = ($urandom_range(0, 15) == 0);
        r_load  = ($urandom_range(0, 7) == 0);
        r_en    = ($urandom_range(0, 3) != 0);
        r_dir   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: r_lv = 32'h9999_9999;
            1: r_lv = 32'h0000_0000;
            2: r_lv = 32'h9999_9998;
            default: r_lv = $urandom;
        endcase
        #1;
        check("rnd_tc1", {31'b0, w_tc1}, {31'b0, model_tc(m1, 1)});
        check("rnd_tc2", {31'b0, w_tc2}, {31'b0, model_tc(m2, 2)});
        check("rnd_tc4", {31'b0, w_tc4}, {31'b0, model_tc(m4, 4)});
        m1 = model_next(m1, 1);
        m2 = model_next(m2, 2);
        m4 = model_next(m4, 4);
        @(posedge clk); #1;
        check("rnd_out1", {28'b0, w_out1}, int_to_bcd(m1, 1));
        check("rnd_out2", {24'b0, w_out2}, int_to_bcd(m2, 2));
        check("rnd_out4", {16'b0, w_out4}, int_to_bcd(m4, 4));
    endtask

    initial begin
        // Reset state
        dstep("reset", 1, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        check("reset_out1", {28'b0, w_out1}, 32'h0);
        check("reset_out4", {16'b0, w_out4}, 32'h0);

        // Basic up count 01..12
        for (int k = 1; k <= 12; k++)
            dstep("up", 0, 1, 0, 0, 8'h00, int_to_bcd(k, 2), 1'b0);

        // Wrap up through 99, then down through 00
        dstep("ld98",   0, 0, 0, 1, 8'h98, 8'h98, 1'b0);
        dstep("up98",   0, 1, 0, 0, 8'h00, 8'h99, 1'b0);
        dstep("wrapup", 0, 1, 0, 0, 8'h00, 8'h00, 1'b1);
        dstep("wrapdn", 0, 1, 1, 0, 8'h00, 8'h99, 1'b1);
        dstep("dn99",   0, 1, 1, 0, 8'h00, 8'h98, 1'b0);

        // Load with illegal digit, load beats enable
        dstep("ld3a",   0, 0, 0, 1, 8'h3A, 8'h30, 1'b0);
        dstep("ld45en", 0, 1, 0, 1, 8'h45, 8'h45, 1'b0);
        dstep("up45",   0, 1, 0, 0, 8'h00, 8'h46, 1'b0);

        // Reset mid-count
        dstep("rst0", 1, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= 7; k++)
            dstep("to07", 0, 1, 0, 0, 8'h00, int_to_bcd(k, 2), 1'b0);
        for (int k = 0; k < 3; k++)
            dstep("midrst", 1, 1, 0, 0, 8'h00, 8'h00, 1'b0);
        dstep("resume1", 0, 1, 0, 0, 8'h00, 8'h01, 1'b0);
        dstep("resume2", 0, 1, 0, 0, 8'h00, 8'h02, 1'b0);

        // Direction flip and hold
        dstep("ld20",  0, 0, 0, 1, 8'h20, 8'h20, 1'b0);
        dstep("dn19",  0, 1, 1, 0, 8'h00, 8'h19, 1'b0);
        dstep("dn18",  0, 1, 1, 0, 8'h00, 8'h18, 1'b0);
        dstep("hold1", 0, 0, 1, 0, 8'h00, 8'h18, 1'b0);
        dstep("hold2", 0, 0, 0, 0, 8'h00, 8'h18, 1'b0);
        dstep("up19",  0, 1, 0, 0, 8'h00, 8'h19, 1'b0);
        dstep("up20",  0, 1, 0, 0, 8'h00, 8'h20, 1'b0);

        // Random phase: resync models with a reset, then 200 random cycles
        r_reset = 1; r_en = 0; r_load = 0; r_dir = 0;
        @(posedge clk); #1;
        m1 = 0; m2 = 0; m4 = 0;
        for (int i = 0; i < 200; i++) rstep();

        // 4-decade wrap 9999 -> 0000 and back
        r_reset = 0; r_en = 0; r_load = 1; r_lv = 32'h0000_9999;
        @(posedge clk); #1;
        m4 = 9999;
        r_load = 0; r_en = 1; r_dir = 0;
        #1;
        check("w4_tc_up", {31'b0, w_tc4}, {31'b0, model_tc(m4, 4)});
        @(posedge clk); #1;
        check("w4_out_up", {16'b0, w_out4}, 32'h0);
        r_dir = 1;
        #1;
        check("w4_tc_dn", {31'b0, w_tc4}, 32'h1);
        @(posedge clk); #1;
        check("w4_out_dn", {16'b0, w_out4}, 32'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
